hls_shared_adder_arbiter: RTL and testbench
===========================================

Name: hls_shared_adder_arbiter

Overview:
- Round-robin arbiter and issue controller that shares one pipelined WIDTH-bit adder among NREQ HLSM controllers.
- Each HLSM state that would otherwise own a dedicated adder ("x <= a + b") instead raises a request, waits for a grant and later collects its tagged result.
- The block lets the scheduler bind many add operations to one functional unit and returns each result to the correct requester.

Parameters:
- NREQ, 4, number of requesting controllers (2..8)
- WIDTH, 32, operand and result width
- LAT, 2, adder pipeline depth in cycles from grant edge to result valid (1..4)

Ports:
- Clk  input  1  clock, rising-edge
- Rst  input  1  reset, synchronous, active-high
- Req  input  NREQ  per-requester add request; held high until granted
- OpA  input  NREQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH]
- OpB  input  NREQ*WIDTH  packed operand B, same packing as OpA
- Gnt  output  NREQ  one-hot grant, combinational, same cycle as the Req it answers
- RVal  output  NREQ  one-hot result-valid pulse, registered
- Result  output  WIDTH  sum for the requester flagged in RVal, registered
- Busy  output  1  high while any issued op is still in the pipeline
- IssueCnt  output  16  count of ops issued since reset

Behaviour:

Reset (Rst=1 at a Clk edge):
- Ptr=0, all pipeline valid bits 0, RVal=0, Result=0, Busy=0, IssueCnt=0.
- Gnt is forced to 0 while Rst=1.

Arbitration, combinational each cycle:
- Scan Req starting at index Ptr, ascending, wrapping modulo NREQ. The first set bit k gets Gnt[k]=1; all other Gnt bits are 0.
- If Req=0, then Gnt=0.
- At most one grant per cycle.

Issue, at the edge where Gnt[k]=1:
- Capture OpA_k, OpB_k and tag k into pipeline stage 1 with valid=1.
- Ptr <= (k+1) mod NREQ.
- IssueCnt <= IssueCnt+1, wrapping 0xFFFF -> 0x0000.
- With no grant: Ptr and IssueCnt hold, and stage 1 valid=0.

Requester handshake:
- A requester seeing Gnt[k]=1 may drop Req at the next edge, or keep it high with new operands for another op. Back-to-back issue to the same requester is allowed when no other requester competes.
- Operands must be stable in the grant cycle only.

Pipeline:
- LAT stages, always advancing; there is no stall input.
- The sum is (A+B) mod 2^WIDTH; carry-out is discarded.
- The add may sit in any stage, but total latency is exactly LAT. Result and RVal[tag] are registered on the LAT-th edge after the grant edge.
- RVal[tag] is a one-cycle pulse.
- Result holds its last value while RVal=0.

Busy:
- Busy=1 whenever any stage valid bit is 1, including the cycle RVal is high.

Boundary conditions:
- All requesters request simultaneously: grants rotate strictly, each requester served once per NREQ cycles, pipeline full every cycle.
- Requester k drops Req before a grant: no grant, no issue, Ptr unchanged.
- Rst asserted with ops in flight: all valid bits cleared at that edge. Those ops never produce RVal, and their requesters reissue after reset.
- Rst and Req high together: no grant and no issue.

Test Plan:
- Only Req[2]=1, OpA=5, OpB=7, LAT=2, Ptr=0: Gnt=0100 that cycle; 2 edges later RVal=0100, Result=12; IssueCnt=1; Ptr=3.
- Req=1111 held 8 cycles: Gnt sequence 0001,0010,0100,1000 repeating. Each RVal mirrors its grant LAT cycles later with the correct sum per index. IssueCnt=8. Busy stays high until the last result.
- Overflow: OpA=0xFFFFFFFF, OpB=0x00000002 -> Result=0x00000001, no other output affected.
- Ptr=2 with Req=1001: Gnt=1000 first, then 0001 next cycle (wrap-around priority).
- Issue on Req[1], assert Rst for 1 cycle one edge later: no RVal ever appears for that op; Busy=0, IssueCnt=0, Ptr=0 after reset.
- Req[0] held 5 cycles with changing operands, others idle: Gnt[0] every cycle, and 5 consecutive RVal[0] pulses carrying the matching sums in order.

Source files
------------

// File: rtl/hls_shared_adder_arbiter.sv
// hls_shared_adder_arbiter: round-robin arbiter sharing one pipelined adder among NREQ HLSM controllers.
// Each pipeline stage carries a one-hot tag (zero means bubble) and the sum, which holds across bubbles.
module hls_shared_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*WIDTH-1:0] OpA,
    input  logic [NREQ*WIDTH-1:0] OpB,
    output logic [NREQ-1:0]       Gnt,
    output logic [NREQ-1:0]       RVal,
    output logic [WIDTH-1:0]      Result,
    output logic                  Busy,
    output logic [15:0]           IssueCnt
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    k;
    logic             hit;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [NREQ-1:0]  t [LAT];
    logic [WIDTH-1:0] s [LAT];

    // Scan descending offsets so the lowest offset from ptr wins.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        idx = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (Req[idx]) begin
                hit = 1'b1;
                k   = idx;
            end
        end
        Gnt = (hit && !Rst) ? (NREQ'(1) << k) : '0;
    end

    assign a = OpA[int'(k)*WIDTH +: WIDTH];
    assign b = OpB[int'(k)*WIDTH +: WIDTH];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr      <= '0;
            IssueCnt <= '0;
            for (int i = 0; i < LAT; i++) begin
                t[i] <= '0;
                s[i] <= '0;
            end
        end else begin
            t[0] <= Gnt;
            if (|Gnt) begin
                s[0]     <= a + b;
                ptr      <= (k == PW'(NREQ-1)) ? '0 : k + 1'b1;
                IssueCnt <= IssueCnt + 1'b1;
            end
            for (int i = 1; i < LAT; i++) begin
                t[i] <= t[i-1];
                if (|t[i-1])
                    s[i] <= s[i-1];
            end
        end
    end

    assign RVal   = t[LAT-1];
    assign Result = s[LAT-1];

    always_comb begin
        Busy = 1'b0;
        for (int i = 0; i < LAT; i++)
            Busy = Busy | (|t[i]);
    end
endmodule

// File: tb/tb_hls_shared_adder_arbiter.sv
// tb_hls_shared_adder_arbiter: directed vector table plus hand sequences for reset-in-flight and back-to-back issue.
module tb_hls_shared_adder_arbiter;
    logic         Clk = 1'b0;
    logic         Rst;
    logic [3:0]   Req;
    logic [127:0] OpA;
    logic [127:0] OpB;
    logic [3:0]   Gnt;
    logic [3:0]   RVal;
    logic [31:0]  Result;
    logic         Busy;
    logic [15:0]  IssueCnt;

    int n_chk = 0;
    int n_fail = 0;

    hls_shared_adder_arbiter #(.NREQ(4), .WIDTH(32), .LAT(2)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .OpA(OpA), .OpB(OpB),
        .Gnt(Gnt), .RVal(RVal), .Result(Result), .Busy(Busy), .IssueCnt(IssueCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]   req;
        logic [127:0] oa;
        logic [127:0] ob;
        logic [3:0]   gnt;
        logic [3:0]   rval;
        logic [31:0]  res;
        logic         busy;
        logic [15:0]  cnt;
    } vec_t;

    // requester k: a = k*16+1, b = k  ->  sums 1, 0x12, 0x23, 0x34
    localparam logic [127:0] OA  = {32'h31, 32'h21, 32'h11, 32'h01};
    localparam logic [127:0] OB  = {32'd3, 32'd2, 32'd1, 32'd0};
    localparam logic [127:0] OA0 = {32'd0, 32'd5, 32'd0, 32'd0};
    localparam logic [127:0] OB0 = {32'd0, 32'd7, 32'd0, 32'd0};
    localparam logic [127:0] OAV = {32'h31, 32'h21, 32'h11, 32'hFFFF_FFFF};
    localparam logic [127:0] OBV = {32'd3, 32'd2, 32'd1, 32'd2};

    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] bb_sum(input int i);
        return 32'(10 + 3*i) + 32'(100*i);
    endfunction

    initial begin
        //                 req      oa   ob   gnt      rval     res         busy  cnt
        tv[0]  = '{4'b0100, OA0, OB0, 4'b0100, 4'b0000, 32'd0,      1'b1, 16'd1};
        tv[1]  = '{4'b0000, OA0, OB0, 4'b0000, 4'b0100, 32'd12,     1'b1, 16'd1};
        tv[2]  = '{4'b0000, OA0, OB0, 4'b0000, 4'b0000, 32'd12,     1'b0, 16'd1};
        tv[3]  = '{4'b1111, OA,  OB,  4'b1000, 4'b0000, 32'd12,     1'b1, 16'd2};
        tv[4]  = '{4'b1111, OA,  OB,  4'b0001, 4'b1000, 32'h34,     1'b1, 16'd3};
        tv[5]  = '{4'b1111, OA,  OB,  4'b0010, 4'b0001, 32'h01,     1'b1, 16'd4};
        tv[6]  = '{4'b1111, OA,  OB,  4'b0100, 4'b0010, 32'h12,     1'b1, 16'd5};
        tv[7]  = '{4'b1111, OA,  OB,  4'b1000, 4'b0100, 32'h23,     1'b1, 16'd6};
        tv[8]  = '{4'b1111, OA,  OB,  4'b0001, 4'b1000, 32'h34,     1'b1, 16'd7};
        tv[9]  = '{4'b1111, OA,  OB,  4'b0010, 4'b0001, 32'h01,     1'b1, 16'd8};
        tv[10] = '{4'b1111, OA,  OB,  4'b0100, 4'b0010, 32'h12,     1'b1, 16'd9};
        tv[11] = '{4'b0000, OA,  OB,  4'b0000, 4'b0100, 32'h23,     1'b1, 16'd9};
        tv[12] = '{4'b0000, OA,  OB,  4'b0000, 4'b0000, 32'h23,     1'b0, 16'd9};
        tv[13] = '{4'b0001, OAV, OBV, 4'b0001, 4'b0000, 32'h23,     1'b1, 16'd10};
        tv[14] = '{4'b0000, OAV, OBV, 4'b0000, 4'b0001, 32'h01,     1'b1, 16'd10};
        tv[15] = '{4'b0010, OA,  OB,  4'b0010, 4'b0000, 32'h01,     1'b1, 16'd11};
        tv[16] = '{4'b1001, OA,  OB,  4'b1000, 4'b0010, 32'h12,     1'b1, 16'd12};
        tv[17] = '{4'b1001, OA,  OB,  4'b0001, 4'b1000, 32'h34,     1'b1, 16'd13};
        tv[18] = '{4'b0000, OA,  OB,  4'b0000, 4'b0001, 32'h01,     1'b1, 16'd13};
        tv[19] = '{4'b0000, OA,  OB,  4'b0000, 4'b0000, 32'h01,     1'b0, 16'd13};

        Rst = 1'b1;
        Req = '0;
        OpA = '0;
        OpB = '0;
        edge_step();
        edge_step();
        chk("reset_rval", 32'(RVal), 32'd0);
        chk("reset_result", Result, 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_cnt", 32'(IssueCnt), 32'd0);
        Req = 4'b1111;
        #1;
        chk("reset_gnt_forced", 32'(Gnt), 32'd0);
        Req = '0;
        Rst = 1'b0;

        for (int r = 0; r < 20; r++) begin
            Req = tv[r].req;
            OpA = tv[r].oa;
            OpB = tv[r].ob;
            #1;
            chk($sformatf("row%0d_gnt", r), 32'(Gnt), 32'(tv[r].gnt));
            edge_step();
            chk($sformatf("row%0d_rval", r), 32'(RVal), 32'(tv[r].rval));
            chk($sformatf("row%0d_result", r), Result, tv[r].res);
            chk($sformatf("row%0d_busy", r), 32'(Busy), 32'(tv[r].busy));
            chk($sformatf("row%0d_cnt", r), 32'(IssueCnt), 32'(tv[r].cnt));
        end

        // Op in flight on requester 1, then reset while Req is still high
        Req = 4'b0010;
        OpA = OA;
        OpB = OB;
        #1;
        chk("inflight_gnt", 32'(Gnt), 32'b0010);
        edge_step();
        chk("inflight_cnt", 32'(IssueCnt), 32'd14);
        Rst = 1'b1;
        #1;
        chk("rst_req_gnt", 32'(Gnt), 32'd0);
        edge_step();
        Rst = 1'b0;
        Req = '0;
        chk("post_rst_busy", 32'(Busy), 32'd0);
        chk("post_rst_cnt", 32'(IssueCnt), 32'd0);
        chk("post_rst_result", Result, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("post_rst_rval%0d", c), 32'(RVal), 32'd0);
            edge_step();
        end
        chk("post_rst_cnt_hold", 32'(IssueCnt), 32'd0);
        Req = 4'b1111;
        #1;
        chk("post_rst_ptr0_gnt", 32'(Gnt), 32'b0001);

        // Back-to-back issue to requester 0 with changing operands
        for (int i = 0; i < 5; i++) begin
            Req = 4'b0001;
            OpA = {96'd0, 32'(10 + 3*i)};
            OpB = {96'd0, 32'(100*i)};
            #1;
            chk($sformatf("b2b%0d_gnt", i), 32'(Gnt), 32'b0001);
            edge_step();
            if (i == 0) begin
                chk("b2b0_rval", 32'(RVal), 32'd0);
            end else begin
                chk($sformatf("b2b%0d_rval", i), 32'(RVal), 32'b0001);
                chk($sformatf("b2b%0d_result", i), Result, bb_sum(i-1));
            end
            chk($sformatf("b2b%0d_busy", i), 32'(Busy), 32'd1);
        end
        Req = '0;
        edge_step();
        chk("b2b_last_rval", 32'(RVal), 32'b0001);
        chk("b2b_last_result", Result, bb_sum(4));
        chk("b2b_last_busy", 32'(Busy), 32'd1);
        edge_step();
        chk("b2b_drain_rval", 32'(RVal), 32'd0);
        chk("b2b_drain_busy", 32'(Busy), 32'd0);
        chk("b2b_drain_result_hold", Result, bb_sum(4));
        chk("b2b_cnt", 32'(IssueCnt), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
